rf_write_queue: RTL and testbench
=================================

Name: rf_write_queue

Overview:
- Buffered writer in front of the 32-entry integer register file.
- Accepts writeback requests from multi-cycle producers (load unit, divider), queues them in order, and drives the register file's single write port one entry per cycle when that port is free.
- Provides two forwarding lookups, aligned with the register file's two read addresses, so the decode stage sees data that is queued but not yet written.

Parameters:
- Width, 32, data width; matches the register file data width.
- Depth, 4, number of queue entries; must be a power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enq_valid  input  1  writeback request present
- enq_ready  output  1  queue can accept this cycle
- enq_rd  input  5  destination register index
- enq_data  input  Width  value to write
- drain_en  input  1  register-file write port free this cycle
- reg_write  output  1  write strobe to the register file
- wr_addr  output  5  register-file write index (head rd)
- wr_data  output  Width  register-file write data (head data)
- lkp_addr1  input  5  forwarding lookup address, port 1
- lkp_addr2  input  5  forwarding lookup address, port 2
- fwd_hit1  output  1  port 1 matches a queued entry
- fwd_data1  output  Width  forwarded data, port 1
- fwd_hit2  output  1  port 2 matches a queued entry
- fwd_data2  output  Width  forwarded data, port 2
- pending  output  log2(Depth)+1  number of valid entries

Behaviour:
- Storage: circular buffer of Depth entries {rd, data}, with head pointer, tail pointer and count.
- Reset (rst_n low, asynchronous):
  - pointers and count = 0; all entry rd/data = 0.
  - reg_write = 0, wr_addr = 0, wr_data = 0.
  - fwd_hit1/2 = 0, fwd_data1/2 = 0, pending = 0, enq_ready = 1.
- Reset mid-operation discards all queued writes; nothing reaches the register file afterwards.
- Drain path (combinational from head state):
  - reg_write = (count != 0) & drain_en.
  - wr_addr / wr_data = head entry.
  - When reg_write = 1, the head pops at the same rising edge the register file captures it.
  - drain_en low holds the head; reg_write stays 0.
- Enqueue:
  - A request is accepted at a rising edge when enq_valid & enq_ready.
  - The entry is written at tail; tail advances and wraps modulo Depth.
- enq_ready = (count < Depth) | ((count != 0) & drain_en). When full, an enqueue is allowed only if a drain occurs in the same cycle.
- x0 filtering: a request with enq_rd = 0 is accepted (handshake completes) but not stored; count and tail are unchanged.
- Simultaneous enqueue and drain: count unchanged, both pointers advance. With count = 0, an enqueue is never drained in the same cycle; no same-cycle bypass to the write port.
- Enqueue latency: accepted at edge N; reg_write can assert in cycle N+1 at the earliest.
- Ordering: strict FIFO; multiple entries to the same rd are written oldest first.
- Forwarding (purely combinational on lkp_addr):
  - fwd_hitK = 1 if lkp_addrK != 0 and any valid entry has rd == lkp_addrK. This includes the head during the cycle it drains, because the register file has not yet updated.
  - fwd_dataK = data of the youngest matching entry, i.e. the closest to tail.
  - No hit gives fwd_hitK = 0 and fwd_dataK = 0.
  - A request being enqueued this cycle is not visible until the next cycle.
  - lkp_addrK = 0 always gives no hit.
- pending = count, updated at the rising edge.
- Pointer wrap: pointers are log2(Depth) bits and roll over naturally; full vs. empty is resolved by count, not by pointer compare.

Test Plan:
- Reset state: assert rst_n=0 mid-cycle with 2 entries queued -> reg_write=0, pending=0, enq_ready=1 immediately; after release with drain_en=1, no write ever issued.
- Single write, held: enqueue rd=5, data=0xDEADBEEF with drain_en=0 -> next cycle pending=1, reg_write=0, fwd_hit1=1/fwd_data1=0xDEADBEEF for lkp_addr1=5. Raise drain_en -> reg_write=1, wr_addr=5, wr_data=0xDEADBEEF for one cycle, then pending=0, fwd_hit1=0.
- Youngest wins: enqueue (rd=3, 0x11) then (rd=3, 0x22) with drain_en=0; lkp_addr2=3 -> fwd_data2=0x22. Drain -> writes 0x11 then 0x22 in consecutive cycles.
- Full with simultaneous enqueue/drain: fill 4 entries (rd=1..4), drain_en=0 -> enq_ready=0. Set drain_en=1 and enq_valid with rd=7, 0x77 -> accepted, pending stays 4, wr_addr=1 written. Further drains write rd=2,3,4,7 in order, exercising pointer wrap.
- x0 filtering: enqueue rd=0, data=0x55 -> handshake completes, pending unchanged, reg_write never asserted; lkp_addr1=0 -> fwd_hit1=0.
- Back-to-back streaming: enqueue every cycle with drain_en=1 for 10 cycles (rd=i, data=i*0x10) -> pending never exceeds 1, each write appears exactly one cycle after acceptance, in order.

Source files
------------

// File: rtl/rf_write_queue.sv
// rtl/rf_write_queue.sv - in-order writeback queue in front of the register-file write port
// Head drains when the write port is free; lookups forward the youngest queued value per register.
module rf_write_queue #(
   parameter int Width = 32,
   parameter int Depth = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic [4:0]                 enq_rd,
   input  logic [Width-1:0]           enq_data,
   input  logic                       drain_en,
   output logic                       reg_write,
   output logic [4:0]                 wr_addr,
   output logic [Width-1:0]           wr_data,
   input  logic [4:0]                 lkp_addr1,
   input  logic [4:0]                 lkp_addr2,
   output logic                       fwd_hit1,
   output logic [Width-1:0]           fwd_data1,
   output logic                       fwd_hit2,
   output logic [Width-1:0]           fwd_data2,
   output logic [$clog2(Depth):0]     pending
);

   localparam int AW = $clog2(Depth);
   localparam logic [AW:0] FULL = (AW+1)'(Depth);

   logic [4:0]       rd_q   [Depth];
   logic [Width-1:0] data_q [Depth];
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;
   logic [AW:0]      count;
   logic             push;
   logic             pop;

   assign pop       = (count != '0) & drain_en;
   assign reg_write = pop;
   // A full queue can still take a request when its head leaves in the same cycle.
   assign enq_ready = (count < FULL) | pop;
   // Writes to x0 complete the handshake but are never stored.
   assign push      = enq_valid & enq_ready & (enq_rd != 5'd0);
   assign wr_addr   = rd_q[head];
   assign wr_data   = data_q[head];
   assign pending   = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < Depth; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            rd_q[tail]   <= enq_rd;
            data_q[tail] <= enq_data;
            tail         <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Walk oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      logic [AW-1:0] idx;
      idx       = '0;
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
      for (int i = 0; i < Depth; i++) begin
         idx = head + AW'(i);
         if ((AW+1)'(i) < count) begin
            if ((lkp_addr1 != 5'd0) && (rd_q[idx] == lkp_addr1)) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = data_q[idx];
            end
            if ((lkp_addr2 != 5'd0) && (rd_q[idx] == lkp_addr2)) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = data_q[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_rf_write_queue.sv
// tb/tb_rf_write_queue.sv - directed and randomized checks of rf_write_queue
// A queue-based reference model tracks the expected contents across all scenarios.
module tb_rf_write_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enq_valid;
   logic        enq_ready;
   logic [4:0]  enq_rd;
   logic [31:0] enq_data;
   logic        drain_en;
   logic        reg_write;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  lkp_addr1;
   logic [4:0]  lkp_addr2;
   logic        fwd_hit1;
   logic [31:0] fwd_data1;
   logic        fwd_hit2;
   logic [31:0] fwd_data2;
   logic [2:0]  pending;

   int checks = 0;
   int errors = 0;

   logic [4:0]  m_rd[$];
   logic [31:0] m_data[$];

   rf_write_queue #(.Width(32), .Depth(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rd(enq_rd), .enq_data(enq_data),
      .drain_en(drain_en), .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
      .lkp_addr1(lkp_addr1), .lkp_addr2(lkp_addr2),
      .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
      .pending(pending)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   // Advance one clock and apply the queue rules to the model using the inputs held across the edge.
   task automatic tick();
      bit drain, acc;
      drain = (m_rd.size() != 0) && drain_en;
      acc   = enq_valid && ((m_rd.size() < 4) || drain);
      @(posedge clk);
      if (drain) begin
         void'(m_rd.pop_front());
         void'(m_data.pop_front());
      end
      if (acc && enq_rd != 5'd0) begin
         m_rd.push_back(enq_rd);
         m_data.push_back(enq_data);
      end
      #2;
   endtask

   function automatic void m_lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
      h = 1'b0;
      d = '0;
      if (a != 5'd0) begin
         for (int i = m_rd.size() - 1; i >= 0; i--) begin
            if (m_rd[i] == a) begin
               h = 1'b1;
               d = m_data[i];
               break;
            end
         end
      end
   endfunction

   task automatic enq(input logic [4:0] rd, input logic [31:0] data);
      enq_valid = 1'b1;
      enq_rd    = rd;
      enq_data  = data;
      tick();
      enq_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %0b want 0", reg_write); end
      checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", pending); end
      checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got %0b want 1", enq_ready); end
      checks++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr got %0d/%h want 0/0", wr_addr, wr_data); end
      checks++; if (fwd_hit1 !== 1'b0 || fwd_data2 !== 32'd0) begin errors++; $display("FAIL reset_fwd got %0b/%h want 0/0", fwd_hit1, fwd_data2); end
      #9 rst_n = 1'b1;
      @(posedge clk);
      #2;
      enq(5'd9, 32'h99);
      enq(5'd10, 32'hAA);
      checks++; if (pending !== 3'd2) begin errors++; $display("FAIL prereset_pending got %0d want 2", pending); end
      #3 rst_n = 1'b0;
      m_rd.delete();
      m_data.delete();
      drain_en = 1'b1;
      #1;
      checks++; if (reg_write !== 1'b0 || pending !== 3'd0 || enq_ready !== 1'b1) begin
         errors++; $display("FAIL midreset got rw=%0b pend=%0d rdy=%0b want 0/0/1", reg_write, pending, enq_ready); end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL postreset_write cycle %0d got %0b want 0", i, reg_write); end
      end
      drain_en = 1'b0;
   endtask

   task automatic test_single_held();
      enq(5'd5, 32'hDEADBEEF);
      lkp_addr1 = 5'd5;
      #1;
      checks++; if (pending !== 3'd1 || reg_write !== 1'b0) begin errors++; $display("FAIL single_held got pend=%0d rw=%0b want 1/0", pending, reg_write); end
      checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd got %0b/%h want 1/deadbeef", fwd_hit1, fwd_data1); end
      drain_en = 1'b1;
      #1;
      checks++; if (reg_write !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
         errors++; $display("FAIL single_drain got %0b/%0d/%h want 1/5/deadbeef", reg_write, wr_addr, wr_data); end
      checks++; if (fwd_hit1 !== 1'b1) begin errors++; $display("FAIL single_fwd_draining got %0b want 1", fwd_hit1); end
      tick();
      checks++; if (pending !== 3'd0 || reg_write !== 1'b0 || fwd_hit1 !== 1'b0 || fwd_data1 !== 32'd0) begin
         errors++; $display("FAIL single_after got pend=%0d rw=%0b hit=%0b d=%h want 0/0/0/0", pending, reg_write, fwd_hit1, fwd_data1); end
      drain_en = 1'b0;
   endtask

   task automatic test_youngest();
      enq(5'd3, 32'h11);
      enq(5'd3, 32'h22);
      lkp_addr2 = 5'd3;
      #1;
      checks++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'h22) begin errors++; $display("FAIL youngest_fwd got %0b/%h want 1/22", fwd_hit2, fwd_data2); end
      drain_en = 1'b1;
      #1;
      checks++; if (reg_write !== 1'b1 || wr_data !== 32'h11) begin errors++; $display("FAIL youngest_first got %0b/%h want 1/11", reg_write, wr_data); end
      tick();
      checks++; if (reg_write !== 1'b1 || wr_data !== 32'h22) begin errors++; $display("FAIL youngest_second got %0b/%h want 1/22", reg_write, wr_data); end
      tick();
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL youngest_empty got %0b want 0", reg_write); end
      drain_en = 1'b0;
   endtask

   task automatic test_full_wrap();
      logic [4:0] order [4];
      order = '{5'd2, 5'd3, 5'd4, 5'd7};
      for (int r = 1; r <= 4; r++) enq(5'(r), 32'h10 * r);
      #1;
      checks++; if (pending !== 3'd4 || enq_ready !== 1'b0) begin errors++; $display("FAIL full got pend=%0d rdy=%0b want 4/0", pending, enq_ready); end
      drain_en  = 1'b1;
      enq_valid = 1'b1;
      enq_rd    = 5'd7;
      enq_data  = 32'h77;
      #1;
      checks++; if (enq_ready !== 1'b1 || reg_write !== 1'b1 || wr_addr !== 5'd1) begin
         errors++; $display("FAIL full_swap got rdy=%0b rw=%0b addr=%0d want 1/1/1", enq_ready, reg_write, wr_addr); end
      tick();
      enq_valid = 1'b0;
      #1;
      checks++; if (pending !== 3'd4) begin errors++; $display("FAIL full_swap_pending got %0d want 4", pending); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (reg_write !== 1'b1 || wr_addr !== order[i]) begin
            errors++; $display("FAIL wrap_order slot %0d got rw=%0b addr=%0d want 1/%0d", i, reg_write, wr_addr, order[i]); end
         tick();
      end
      checks++; if (pending !== 3'd0) begin errors++; $display("FAIL wrap_empty got %0d want 0", pending); end
      checks++; if (m_data.size() != 0) begin errors++; $display("FAIL wrap_model got %0d want 0", m_data.size()); end
      drain_en = 1'b0;
   endtask

   task automatic test_x0();
      drain_en  = 1'b1;
      enq_valid = 1'b1;
      enq_rd    = 5'd0;
      enq_data  = 32'h55;
      #1;
      checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %0b want 1", enq_ready); end
      tick();
      enq_valid = 1'b0;
      lkp_addr1 = 5'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (pending !== 3'd0 || reg_write !== 1'b0 || fwd_hit1 !== 1'b0) begin
            errors++; $display("FAIL x0_filtered got pend=%0d rw=%0b hit=%0b want 0/0/0", pending, reg_write, fwd_hit1); end
         tick();
      end
      drain_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      drain_en = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         enq_valid = (i <= 10);
         enq_rd    = 5'(i);
         enq_data  = 32'h10 * i;
         #1;
         if (i == 1) begin
            checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL b2b_first got %0b want 0", reg_write); end
         end else begin
            checks++; if (reg_write !== 1'b1 || wr_addr !== 5'(i - 1) || wr_data !== 32'h10 * (i - 1)) begin
               errors++; $display("FAIL b2b_write %0d got %0b/%0d/%h want 1/%0d/%h", i, reg_write, wr_addr, wr_data, i - 1, 32'h10 * (i - 1)); end
         end
         tick();
         checks++; if (pending > 3'd1) begin errors++; $display("FAIL b2b_pending got %0d want <=1", pending); end
      end
      enq_valid = 1'b0;
      drain_en  = 1'b0;
   endtask

   task automatic test_random();
      logic        h1, h2;
      logic [31:0] d1, d2;
      bit          exp_rw, exp_rdy;
      for (int c = 0; c < 400; c++) begin
         enq_valid = ($urandom_range(0, 2) != 0);
         enq_rd    = 5'($urandom_range(0, 7));
         enq_data  = $urandom;
         drain_en  = ($urandom_range(0, 2) == 0);
         lkp_addr1 = 5'($urandom_range(0, 7));
         lkp_addr2 = 5'($urandom_range(0, 7));
         #1;
         exp_rw  = (m_rd.size() != 0) && drain_en;
         exp_rdy = (m_rd.size() < 4) || exp_rw;
         m_lookup(lkp_addr1, h1, d1);
         m_lookup(lkp_addr2, h2, d2);
         checks++; if (reg_write !== exp_rw || enq_ready !== exp_rdy || pending !== 3'(m_rd.size())) begin
            errors++; $display("FAIL rand_ctrl c%0d got rw=%0b rdy=%0b pend=%0d want %0b/%0b/%0d", c, reg_write, enq_ready, pending, exp_rw, exp_rdy, m_rd.size()); end
         if (m_rd.size() != 0) begin
            checks++; if (wr_addr !== m_rd[0] || wr_data !== m_data[0]) begin
               errors++; $display("FAIL rand_head c%0d got %0d/%h want %0d/%h", c, wr_addr, wr_data, m_rd[0], m_data[0]); end
         end
         checks++; if (fwd_hit1 !== h1 || fwd_data1 !== d1 || fwd_hit2 !== h2 || fwd_data2 !== d2) begin
            errors++; $display("FAIL rand_fwd c%0d got %0b/%h %0b/%h want %0b/%h %0b/%h", c, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, h1, d1, h2, d2); end
         tick();
      end
      enq_valid = 1'b0;
      drain_en  = 1'b0;
   endtask

   initial begin
      enq_valid = 1'b0;
      enq_rd    = '0;
      enq_data  = '0;
      drain_en  = 1'b0;
      lkp_addr1 = '0;
      lkp_addr2 = '0;
      test_reset();
      test_single_held();
      test_youngest();
      test_full_wrap();
      test_x0();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
